ehl_ahb_cmd_master: RTL and testbench



---
 rtl/ehl_ahb_cmd_master_if.sv | 24 ++
 rtl/ehl_ahb_cmd_master.sv | 119 +++++++++++
 tb/tb_ehl_ahb_cmd_master.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ehl_ahb_cmd_master_if.sv
// AHB-Lite initiator-side signal bundle: the master drives the address/control
// and write data, the slave side returns read data, ready and response.
interface ehl_ahb_cmd_master_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ehl_ahb_cmd_master.sv
// Single-transfer AHB-Lite initiator: a valid/ready command stream becomes
// pipelined NONSEQ/SINGLE transfers with one in-order response per command.
module ehl_ahb_cmd_master (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [31:0]                cmd_addr,
  input  logic [2:0]                 cmd_size,
  input  logic [31:0]                cmd_wdata,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [7:0]                 rsp_wait,
  ehl_ahb_cmd_master_if.master       ahb
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address phase stage
  logic        ap_valid_reg;
  logic [31:0] ap_addr_reg;
  logic        ap_write_reg;
  logic [2:0]  ap_size_reg;
  logic [31:0] ap_wdata_reg;

  // Data phase stage
  logic        dp_valid_reg;
  logic        dp_write_reg;
  logic [31:0] dp_wdata_reg;
  logic [7:0]  wait_cnt_reg;

  logic        cancel_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;
  logic [7:0]  rsp_wait_reg;

  logic nonseq;
  logic adv;
  logic accept;
  logic retire;
  logic err_first;
  logic unused_hresp;

  assign nonseq    = ap_valid_reg & ~cancel_reg;
  assign adv       = ahb.hready & nonseq;
  assign cmd_ready = ~hreset & (~ap_valid_reg | adv);
  assign accept    = cmd_valid & cmd_ready;
  assign retire    = dp_valid_reg & ahb.hready;
  // First ERROR cycle: withdraw the pending address phase for the second cycle.
  assign err_first = dp_valid_reg & ~ahb.hready & ahb.hresp[0];
  assign unused_hresp = ahb.hresp[1];

  assign ahb.htrans = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.haddr  = ap_addr_reg;
  assign ahb.hwrite = ap_write_reg;
  assign ahb.hsize  = ap_size_reg;
  assign ahb.hburst = 3'b000;
  assign ahb.hprot  = 4'b0011;
  assign ahb.hwdata = dp_wdata_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_wait  = rsp_wait_reg;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ap_valid_reg  <= 1'b0;
      ap_addr_reg   <= '0;
      ap_write_reg  <= 1'b0;
      ap_size_reg   <= '0;
      ap_wdata_reg  <= '0;
      dp_valid_reg  <= 1'b0;
      dp_write_reg  <= 1'b0;
      dp_wdata_reg  <= '0;
      wait_cnt_reg  <= '0;
      cancel_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_wait_reg  <= '0;
    end else begin
      if (accept) begin
        ap_valid_reg <= 1'b1;
        ap_addr_reg  <= cmd_addr;
        ap_write_reg <= cmd_write;
        ap_size_reg  <= cmd_size;
        ap_wdata_reg <= cmd_wdata;
      end else if (adv) begin
        ap_valid_reg <= 1'b0;
      end

      if (adv) begin
        dp_valid_reg <= 1'b1;
        dp_write_reg <= ap_write_reg;
        dp_wdata_reg <= ap_wdata_reg;
        wait_cnt_reg <= '0;
      end else if (retire) begin
        dp_valid_reg <= 1'b0;
      end else if (dp_valid_reg && !ahb.hready && wait_cnt_reg != 8'hFF) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end

      if (retire) begin
        cancel_reg <= 1'b0;
      end else if (err_first) begin
        cancel_reg <= 1'b1;
      end

      rsp_valid_reg <= retire;
      rsp_err_reg   <= retire & ahb.hresp[0];
      rsp_rdata_reg <= (retire && !dp_write_reg) ? ahb.hrdata : 32'h0;
      rsp_wait_reg  <= retire ? wait_cnt_reg : 8'h0;
    end
  end
endmodule

// File: tb/tb_ehl_ahb_cmd_master.sv
// Directed and randomized checks of ehl_ahb_cmd_master against a per-command
// expectation model and a scripted AHB slave.
module tb_ehl_ahb_cmd_master;
  localparam int MAXC = 128;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_wait;

  always #5 hclk = ~hclk;

  ehl_ahb_cmd_master_if ahb ();

  ehl_ahb_cmd_master dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_wait  (rsp_wait),
    .ahb       (ahb)
  );

  // Expectation model (written by the main sequence only)
  logic        exp_write [MAXC];
  logic [31:0] exp_addr  [MAXC];
  logic [2:0]  exp_size  [MAXC];
  logic [31:0] exp_wdata [MAXC];
  logic [31:0] exp_rdata [MAXC];
  logic        exp_err   [MAXC];
  logic [7:0]  exp_wait  [MAXC];
  int          plan_waits[MAXC];
  logic        plan_err  [MAXC];
  longint      acc_t     [MAXC];
  logic [31:0] model_mem [logic [31:0]];
  int          n_cmd;

  // Observations (written by the slave / response monitor only)
  logic [31:0] obs_ap_addr [MAXC];
  logic        obs_ap_write[MAXC];
  logic [2:0]  obs_ap_size [MAXC];
  longint      ap_t        [MAXC];
  logic [31:0] obs_wd      [MAXC];
  logic [31:0] obs_rdata   [MAXC];
  logic        obs_err     [MAXC];
  logic [7:0]  obs_wait    [MAXC];
  longint      rsp_t       [MAXC];
  int          ap_n, rsp_n, ap_viol, htrans_bad, wd_unstable;
  logic [31:0] smem [logic [31:0]];

  int n_checks, n_fail, vptr;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h3C5A_0F96;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  // Present one command, wait for acceptance, and record what the bus must show.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                       input logic [31:0] wd, input int waits, input logic err,
                       output int stalls);
    int  k;
    bit  got;
    k = n_cmd;
    exp_write[k] = wr;
    exp_addr[k]  = addr;
    exp_size[k]  = sz;
    exp_wdata[k] = wd;
    exp_err[k]   = err;
    exp_wait[k]  = (waits + int'(err) > 255) ? 8'd255 : 8'(waits + int'(err));
    if (wr) begin
      exp_rdata[k] = 32'h0;
      if (!err) model_mem[addr] = wd;
    end else begin
      exp_rdata[k] = model_mem.exists(addr) ? model_mem[addr] : dflt(addr);
    end
    plan_waits[k] = waits;
    plan_err[k]   = err;
    n_cmd++;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = sz;
    cmd_wdata = wd;
    stalls = 0;
    got = 0;
    while (!got) begin
      @(negedge hclk);
      if (cmd_ready === 1'b1) got = 1;
      else begin
        stalls++;
        if (stalls > 2000) begin
          chk("accept_timeout", 32'(stalls), 32'd0);
          got = 1;
        end
      end
    end
    @(posedge hclk);
    acc_t[k] = $time;
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for all responses up to command 'upto' and compare them in order.
  task automatic verify(input int upto);
    int guard;
    guard = 0;
    while (rsp_n < upto && guard < 4000) begin
      @(posedge hclk);
      guard++;
    end
    #1;
    chk("rsp_count", 32'(rsp_n), 32'(upto));
    for (int k = vptr; k < upto; k++) begin
      chk($sformatf("haddr[%0d]", k), obs_ap_addr[k], exp_addr[k]);
      chk($sformatf("hwrite[%0d]", k), 32'(obs_ap_write[k]), 32'(exp_write[k]));
      chk($sformatf("hsize[%0d]", k), 32'(obs_ap_size[k]), 32'(exp_size[k]));
      chk($sformatf("rsp_rdata[%0d]", k), obs_rdata[k], exp_rdata[k]);
      chk($sformatf("rsp_err[%0d]", k), 32'(obs_err[k]), 32'(exp_err[k]));
      chk($sformatf("rsp_wait[%0d]", k), 32'(obs_wait[k]), 32'(exp_wait[k]));
      chk($sformatf("latency[%0d]", k), 32'(rsp_t[k] - ap_t[k]),
          32'(10 * (plan_waits[k] + int'(plan_err[k]) + 1) + 5));
      if (exp_write[k]) chk($sformatf("hwdata[%0d]", k), obs_wd[k], exp_wdata[k]);
    end
    vptr = upto;
  endtask

  // Scripted AHB slave: snapshot the bus mid-cycle, act at the edge, drive after it.
  initial begin : slave
    logic [1:0]  sn_htrans, sn_hresp;
    logic [31:0] sn_haddr, sn_hwdata, s_addr, s_wd0;
    logic        sn_hwrite, sn_hready, sn_hreset;
    logic [2:0]  sn_hsize;
    logic        s_active, s_write, s_err, s_first, s_phase, prev_hold, prev_err1;
    logic [35:0] prev_ap;
    int          s_waits, s_idx;
    ahb.hready = 1'b1;
    ahb.hresp  = 2'b00;
    ahb.hrdata = 32'h0;
    s_active = 0; s_write = 0; s_err = 0; s_first = 0; s_phase = 0;
    prev_hold = 0; prev_err1 = 0; prev_ap = '0; s_addr = '0; s_wd0 = '0;
    s_waits = 0; s_idx = 0;
    ap_n = 0; ap_viol = 0; htrans_bad = 0; wd_unstable = 0;
    smem[32'h1000] = 32'hCAFE0001;
    forever begin
      @(negedge hclk);
      sn_htrans = ahb.htrans;  sn_haddr = ahb.haddr;   sn_hwrite = ahb.hwrite;
      sn_hsize  = ahb.hsize;   sn_hwdata = ahb.hwdata; sn_hready = ahb.hready;
      sn_hresp  = ahb.hresp;   sn_hreset = hreset;
      @(posedge hclk);
      if (sn_hreset) begin
        s_active = 0;
        prev_hold = 0;
      end else begin
        if (sn_htrans != 2'b00 && sn_htrans != 2'b10) htrans_bad++;
        if (prev_hold) begin
          if (sn_htrans == 2'b10) begin
            if ({sn_haddr, sn_hwrite, sn_hsize} !== prev_ap) ap_viol++;
          end else if (!prev_err1) begin
            ap_viol++;
          end
        end
        prev_hold = (sn_htrans == 2'b10) && !sn_hready;
        prev_ap   = {sn_haddr, sn_hwrite, sn_hsize};
        prev_err1 = s_active && !sn_hready && sn_hresp[0];
        if (s_active) begin
          if (s_write) begin
            if (s_first) begin
              s_wd0 = sn_hwdata;
              s_first = 0;
            end else if (sn_hwdata !== s_wd0) begin
              wd_unstable++;
            end
          end
          if (sn_hready) begin
            if (s_write) begin
              obs_wd[s_idx] = sn_hwdata;
              if (!s_err) smem[s_addr] = sn_hwdata;
            end
            s_active = 0;
          end
        end
        if (sn_htrans == 2'b10 && sn_hready && ap_n < MAXC) begin
          obs_ap_addr[ap_n]  = sn_haddr;
          obs_ap_write[ap_n] = sn_hwrite;
          obs_ap_size[ap_n]  = sn_hsize;
          ap_t[ap_n] = $time;
          s_idx   = ap_n;
          ap_n++;
          s_active = 1;
          s_write  = sn_hwrite;
          s_addr   = sn_haddr;
          s_waits  = plan_waits[s_idx];
          s_err    = plan_err[s_idx];
          s_phase  = 0;
          s_first  = 1;
        end
      end
      #1;
      if (s_active && s_waits > 0) begin
        ahb.hready = 1'b0;
        ahb.hresp  = {1'($urandom_range(0, 1)), 1'b0};
        ahb.hrdata = $urandom;
        s_waits--;
      end else if (s_active && s_err && !s_phase) begin
        ahb.hready = 1'b0;
        ahb.hresp  = {1'($urandom_range(0, 1)), 1'b1};
        ahb.hrdata = $urandom;
        s_phase = 1;
      end else if (s_active) begin
        ahb.hready = 1'b1;
        ahb.hresp  = {1'($urandom_range(0, 1)), s_err};
        ahb.hrdata = s_write ? $urandom : (smem.exists(s_addr) ? smem[s_addr] : dflt(s_addr));
      end else begin
        ahb.hready = 1'b1;
        ahb.hresp  = {1'($urandom_range(0, 1)), 1'b0};
        ahb.hrdata = $urandom;
      end
    end
  end

  initial begin : rsp_mon
    rsp_n = 0;
    forever begin
      @(negedge hclk);
      if (hreset === 1'b0 && rsp_valid === 1'b1 && rsp_n < MAXC) begin
        obs_rdata[rsp_n] = rsp_rdata;
        obs_err[rsp_n]   = rsp_err;
        obs_wait[rsp_n]  = rsp_wait;
        rsp_t[rsp_n]     = $time;
        rsp_n++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int st, b;
    int st4[4];
    logic        wr, er;
    logic [31:0] ad;
    logic [2:0]  sz;
    int          wt;
    n_checks = 0; n_fail = 0; n_cmd = 0; vptr = 0;
    model_mem[32'h1000] = 32'hCAFE0001;

    // Reset held three edges with a command already presented.
    hreset = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000; cmd_size = 3'd2; cmd_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge hclk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_htrans",    32'(ahb.htrans), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_haddr",     ahb.haddr, 32'd0);
      chk("rst_hwrite",    32'(ahb.hwrite), 32'd0);
      chk("rst_hsize",     32'(ahb.hsize), 32'd0);
      chk("rst_hwdata",    ahb.hwdata, 32'd0);
      chk("rst_hburst",    32'(ahb.hburst), 32'd0);
      chk("rst_hprot",     32'(ahb.hprot), 32'h3);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   32'(rsp_err), 32'd0);
      chk("rst_rsp_wait",  32'(rsp_wait), 32'd0);
    end
    chk("rst_no_ap", 32'(ap_n), 32'd0);
    hreset = 1'b0;

    // Single zero-wait read
    issue(1'b0, 32'h1000, 3'd2, 32'h0, 0, 1'b0, st);
    chk("s1_first_accept_stalls", 32'(st), 32'd0);
    verify(1);
    chk("s1_ap_time", 32'(ap_t[0] - acc_t[0]), 32'd10);
    chk("s1_single_ap", 32'(ap_n), 32'd1);

    // Write with three wait states
    idle(2);
    issue(1'b1, 32'h20, 3'd2, 32'h55AA, 3, 1'b0, st);
    verify(2);

    // Four back-to-back zero-wait writes
    idle(2);
    b = n_cmd;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'(4 * i), 3'd2, $urandom, 0, 1'b0, st4[i]);
    verify(b + 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_stall[%0d]", i), 32'(st4[i]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_ap_gap[%0d]", i), 32'(ap_t[b + i + 1] - ap_t[b + i]), 32'd10);
      chk($sformatf("b2b_rsp_gap[%0d]", i), 32'(rsp_t[b + i + 1] - rsp_t[b + i]), 32'd10);
    end

    // ERROR on a read while the next read sits in the address phase
    idle(2);
    b = n_cmd;
    issue(1'b0, 32'h100, 3'd2, 32'h0, 0, 1'b1, st);
    issue(1'b0, 32'h104, 3'd2, 32'h0, 0, 1'b0, st);
    verify(b + 2);
    chk("err_reissue_time", 32'(ap_t[b + 1] - rsp_t[b]), 32'd5);

    // Long stall saturates the wait count
    idle(2);
    issue(1'b0, 32'h40, 3'd1, 32'h0, 300, 1'b0, st);
    verify(n_cmd);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      ad = 32'h200 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      sz = 3'($urandom_range(0, 2));
      wt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      er = ($urandom_range(0, 7) == 0);
      issue(wr, ad, sz, $urandom, wt, er, st);
      idle(int'($urandom_range(0, 2)));
    end
    verify(n_cmd);

    idle(5);
    chk("total_rsp", 32'(rsp_n), 32'(n_cmd));
    chk("total_ap", 32'(ap_n), 32'(n_cmd));
    chk("ap_stability", 32'(ap_viol), 32'd0);
    chk("htrans_legal", 32'(htrans_bad), 32'd0);
    chk("hwdata_stability", 32'(wd_unstable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
